// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_REQ AXI-Stream sources share one master link, grant locked until tlast.
// Optional stall timeout enabled by defining AXIS_ARB_TIMEOUT_EN.
module axis_rr_arbiter #(
   parameter int unsigned  NUM_REQ        = 4,
   parameter int unsigned  TIMEOUT_CYCLES = 255,
   localparam int unsigned IDW            = $clog2(NUM_REQ)
) (
   input  logic                   axi_aclk,
   input  logic                   axi_aresetn,
   input  logic [NUM_REQ-1:0]     s_tvalid,
   input  logic [32*NUM_REQ-1:0]  s_tdata,
   input  logic [4*NUM_REQ-1:0]   s_tstrb,
   input  logic [4*NUM_REQ-1:0]   s_tkeep,
   input  logic [2*NUM_REQ-1:0]   s_tuser,
   input  logic [NUM_REQ-1:0]     s_tlast,
   output logic [NUM_REQ-1:0]     s_tready,
   output logic                   m_tvalid,
   output logic [31:0]            m_tdata,
   output logic [3:0]             m_tstrb,
   output logic [3:0]             m_tkeep,
   output logic [1:0]             m_tuser,
   output logic                   m_tlast,
   input  logic                   m_tready,
   output logic                   busy,
   output logic [IDW-1:0]         grant_id,
   output logic                   timeout_pulse
);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("axis_rr_arbiter: NUM_REQ must be in 2..8");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("axis_rr_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic {
      ST_IDLE,
      ST_LOCK
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   grant_q, grant_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [IDW-1:0]   winner;

`ifdef AXIS_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;
`endif

   // Search starts one past the previous winner so every source is served within NUM_REQ packets.
   always_comb begin
      int unsigned idx;
      logic        found;
      idx    = 0;
      found  = 1'b0;
      winner = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(last_q) + k) % NUM_REQ;
         if (!found && s_tvalid[idx[IDW-1:0]]) begin
            winner = IDW'(idx);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      m_tvalid = 1'b0;
      m_tdata  = '0;
      m_tstrb  = '0;
      m_tkeep  = '0;
      m_tuser  = '0;
      m_tlast  = 1'b0;
      s_tready = '0;
      if (state_q == ST_LOCK) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDW'(i)) begin
               m_tvalid    = s_tvalid[i];
               m_tdata     = s_tdata[i*32 +: 32];
               m_tstrb     = s_tstrb[i*4 +: 4];
               m_tkeep     = s_tkeep[i*4 +: 4];
               m_tuser     = s_tuser[i*2 +: 2];
               m_tlast     = s_tlast[i];
               s_tready[i] = m_tready;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
`ifdef AXIS_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef AXIS_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (|s_tvalid) begin
               grant_d = winner;
               state_d = ST_LOCK;
            end
         end
         ST_LOCK: begin
            if (m_tvalid && m_tready && m_tlast) begin
               state_d = ST_IDLE;
               last_d  = grant_q;
            end
`ifdef AXIS_ARB_TIMEOUT_EN
            // Counter measures consecutive invalid cycles of the granted source only.
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
               state_d = ST_IDLE;
               last_d  = grant_q;
               cnt_d   = '0;
               pulse_d = 1'b1;
            end else if (m_tvalid) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= IDW'(NUM_REQ - 1);
`ifdef AXIS_ARB_TIMEOUT_EN
         cnt_q   <= '0;
         pulse_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
`ifdef AXIS_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
`endif
      end
   end

   assign busy     = (state_q == ST_LOCK);
   assign grant_id = grant_q;

`ifdef AXIS_ARB_TIMEOUT_EN
   assign timeout_pulse = pulse_q;
`else
   assign timeout_pulse = 1'b0;
`endif

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream master link (feeding an `axis_slave`-style backend) among `NUM_REQ` upstream stream sources. A grant is locked for a whole packet, from the first beat through the `tlast` beat, so beats of different packets are never interleaved. The arbiter sits between the per-source stream producers and the single downstream AXI-Stream port.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 255: stall limit, used only when `AXIS_ARB_TIMEOUT_EN` is defined.
- `IDW` = `$clog2(NUM_REQ)`: derived; not overridable.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `axi_aclk` in 1: clock.
- `axi_aresetn` in 1: synchronous active-low reset.
- Slave side, all vectors packed with requester `i` at slice `i`:
  - `s_tvalid` in NUM_REQ
  - `s_tdata` in 32*NUM_REQ
  - `s_tstrb` in 4*NUM_REQ
  - `s_tkeep` in 4*NUM_REQ
  - `s_tuser` in 2*NUM_REQ
  - `s_tlast` in NUM_REQ
  - `s_tready` out NUM_REQ
- Master side:
  - `m_tvalid` out 1
  - `m_tdata` out 32
  - `m_tstrb` out 4
  - `m_tkeep` out 4
  - `m_tuser` out 2
  - `m_tlast` out 1
  - `m_tready` in 1
- Status:
  - `busy` out 1: high while in LOCK.
  - `grant_id` out IDW: the currently locked source; holds the last grant while in IDLE.
  - `timeout_pulse` out 1: one-cycle flag when a grant is force-released.

## Operation
State machine:
- IDLE: if any `s_tvalid` is high, pick the winner, load `grant_id`, and go to LOCK on the next edge. With no requests, stay in IDLE.
- LOCK:
  - Route the granted source combinationally to the master port.
  - Leave LOCK when a beat transfers with `tlast` (`m_tvalid & m_tready & m_tlast`), going to IDLE.
  - Leave LOCK on timeout (see Configuration), going to IDLE.

Winner selection:
- Search for the first set `s_tvalid` starting at `(last_grant+1) mod NUM_REQ` and wrapping around.
- `last_grant` updates to `grant_id` when LOCK exits.

Datapath:
- In LOCK, `m_*` = the granted slice of `s_*`.
- `s_tready[grant_id]` = `m_tready`; every other `s_tready` bit is 0.
- In IDLE, all `m_*` outputs are 0 and `s_tready` is all-zero.

Boundary conditions:
- A granted source that drops `tvalid` mid-packet keeps the lock; `m_tvalid` follows it low.
- A source raising `tvalid` while another source holds the grant waits; it is never starved, because the round-robin search always starts after the last winner.
- A single-beat packet (first beat carries `tlast`) gets a lock lasting one transfer cycle.
- `s_tvalid` deasserting during the IDLE decision cycle: the decision uses that cycle's sample. If the winner has dropped `tvalid` by the LOCK cycle, LOCK simply waits for it.
- Reset mid-packet: next state is IDLE and the packet is truncated; no `tlast` is generated.

## Timing
Reset values:
- State = IDLE, `grant_id` = 0, `last_grant` = NUM_REQ-1 (first priority goes to source 0).
- `busy` = 0, `timeout_pulse` = 0, timeout counter = 0.
- All `m_*` = 0 and `s_tready` = 0.

Latency:
- One cycle from `s_tvalid` rising (in IDLE) to `m_tvalid` and `busy` high.
- The master-side path in LOCK is combinational, with zero added latency per beat.
- Minimum gap between packets is one IDLE cycle, so peak throughput is L/(L+1) for L-beat packets.

Handshake:
- A beat transfers on an edge where `m_tvalid & m_tready`.
- `m_*` stays stable while `m_tvalid & ~m_tready`, because the granted source must hold its data by AXI-Stream rules.

## Configuration
`AXIS_ARB_TIMEOUT_EN`

Defined:
- In LOCK, a counter increments on every cycle in which the granted source's `s_tvalid` is 0, and resets to 0 on any cycle in which it is 1.
- When the counter reaches `TIMEOUT_CYCLES`:
  - go to IDLE, update `last_grant`, and clear the counter;
  - assert `timeout_pulse` for exactly one cycle, on the cycle the state reads IDLE.
- A stall longer than the limit therefore releases the link, and the rest of that packet is re-arbitrated later like any other traffic.

Undefined:
- No counter is instantiated.
- `timeout_pulse` is tied to 0.
- The lock is held indefinitely until `tlast`.

## Test plan
- Reset, then `s_tvalid` = 4'b0001 with a 3-beat packet (data 0xA0..0xA2) and `m_tready` = 1:
  - `busy` rises one cycle later, `grant_id` = 0, and three beats come out in order with `tlast` on 0xA2;
  - `busy` is back to 0 on the next cycle.
- All four sources continuously valid, each sending 2-beat packets:
  - grant order is 0,1,2,3,0 with one IDLE cycle between packets;
  - no beats are interleaved.
- Source 2 locked, and source 0 raises `tvalid` mid-packet:
  - `s_tready[0]` stays 0 until source 2's `tlast` transfers;
  - the next grant is 3 if valid, otherwise 0.
- `m_tready` toggles 1,0,1,0 during a 4-beat packet:
  - `m_*` holds stable on the ready-low cycles;
  - exactly 4 transfers occur and `s_tready` mirrors `m_tready`.
- With `AXIS_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, the granted source stalls its `tvalid` after beat 1:
  - `timeout_pulse` is high for exactly 1 cycle, 9 cycles after the stall begins (8 counting cycles plus the release edge);
  - the grant then moves to the next valid source.
- `axi_aresetn` asserted mid-packet for 1 cycle:
  - next cycle shows state IDLE, `m_tvalid` = 0, `s_tready` = 0 and `grant_id` = 0;
  - re-arbitration starts at source 0.
